// File: rtl/instr_fetch_queue.sv
// Purpose: MIPS fetch stage; owns the fetch PC, issues word reads and queues returned words for decode.
// Latency: gnt in cycle N -> rvalid earliest N+1 -> instr_valid_o earliest N+2 (no bypass).
// Backpressure: decode stalls via instr_ready_i; requests stop when queued+in-flight words reach DEPTH.
//
// Ports:
//   clk_i, rst_i                        clock, synchronous active-high reset
//   redirect_i, redirect_pc_i           PC change request (flushes queue, drops in-flight reads)
//   imem_req_o, imem_addr_o, imem_gnt_i instruction memory request channel
//   imem_rvalid_i, imem_rdata_i         in-order read responses, never stalled
//   instr_valid_o, instr_o, instr_pc_o  head instruction presented to decode
//   pc_plus4_o                          instr_pc_o + 4 (branch target / link base)
//   instr_ready_i                       decode consumes head when valid && ready
module instr_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic [31:0] pc_plus4_o,
  input  logic        instr_ready_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q;
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW-1:0] aq_rd_q, aq_wr_q;

  // Instruction queue (word + its address) and the address FIFO of granted reads.
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   addr_mem  [DEPTH];

  logic          grant, push, pop;
  logic [CW:0]   occupancy;
  logic          unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc_i[1:0];

  // Credit: every granted read is guaranteed a queue slot, so rvalid never needs a stall.
  assign occupancy  = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem_req_o = !rst_i && (state_q == RUN) && (occupancy < (CW+1)'(DEPTH));
  assign imem_addr_o = fetch_pc_q;
  assign grant       = imem_req_o && imem_gnt_i;

  // Responses are dropped while stale reads are draining or when a redirect lands this cycle.
  assign push = imem_rvalid_i && (discard_q == '0) && !redirect_i;

  assign instr_valid_o = (count_q != '0);
  assign pop           = instr_valid_o && instr_ready_i && !redirect_i;
  assign instr_o       = instr_valid_o ? instr_mem[rd_ptr_q] : 32'h0;
  assign instr_pc_o    = instr_valid_o ? pc_mem[rd_ptr_q]    : 32'h0;
  assign pc_plus4_o    = instr_pc_o + 32'd4;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid_i);

    if (grant) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (imem_rvalid_i && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end

    // Every read still in flight after this cycle belongs to the old path, including
    // a grant taken in the redirect cycle itself.
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      discard_d  = outstanding_d;
    end

    case (state_q)
      RUN:     if (discard_d != '0) state_d = FLUSH;
      FLUSH:   if (discard_d == '0) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      aq_rd_q       <= '0;
      aq_wr_q       <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;

      // The address FIFO tracks every read, stale or not, so it is never flushed.
      if (grant)         aq_wr_q <= aq_wr_q + AW'(1);
      if (imem_rvalid_i) aq_rd_q <= aq_rd_q + AW'(1);

      if (redirect_i) begin
        count_q  <= '0;
        rd_ptr_q <= wr_ptr_q;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant) begin
      addr_mem[aq_wr_q] <= fetch_pc_q;
    end
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata_i;
      pc_mem[wr_ptr_q]    <= addr_mem[aq_rd_q];
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Purpose: randomized and directed bench for instr_fetch_queue against a queue-based reference.
// Latency: checks the N -> N+1 -> N+2 gnt/rvalid/valid pipeline through the reference queues.
// Backpressure: random decode ready and memory grant; credit limit checked every cycle.
module tb_instr_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic [31:0] pc_plus4_o;
  logic        instr_ready_i = 1'b0;

  instr_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_valid_o(instr_valid_o),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .pc_plus4_o   (pc_plus4_o),
    .instr_ready_i(instr_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } inflight_t;

  // Reference state: words the decode side should see, reads the memory still owes,
  // how many of those belong to an abandoned path, and the next fetch address.
  logic [31:0] mq[$];
  inflight_t   inflight[$];
  logic [31:0] delivered[$];
  logic [31:0] delivered_p4[$];
  int          stale;
  logic [31:0] mfetch;
  logic [31:0] exp_seq;
  int          cyc;
  int          n_consumed;
  int          n_grants;

  int n_checks = 0;
  int n_fail   = 0;

  int gnt_pct, ready_pct, redir_pct, lat_lo, lat_hi;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] t;
    t = a * 32'h9E37_79B1;
    return t ^ 32'hC3C3_0F0F;
  endfunction

  function automatic logic [31:0] get_del(input int i);
    return (delivered.size() > i) ? delivered[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] get_p4(input int i);
    return (delivered_p4.size() > i) ? delivered_p4[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i         = 1'b1;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    redirect_i    = 1'b0;
    instr_ready_i = 1'b0;
    @(negedge clk_i);
    check_eq("rst_req",    imem_req_o,    32'd0);
    check_eq("rst_addr",   imem_addr_o,   RESET_PC);
    check_eq("rst_valid",  instr_valid_o, 32'd0);
    check_eq("rst_instr",  instr_o,       32'd0);
    check_eq("rst_pc",     instr_pc_o,    32'd0);
    check_eq("rst_plus4",  pc_plus4_o,    32'd4);
    rst_i = 1'b0;
    mq.delete();
    inflight.delete();
    delivered.delete();
    delivered_p4.delete();
    stale   = 0;
    mfetch  = RESET_PC;
    exp_seq = RESET_PC;
  endtask

  task automatic step(input bit force_redir, input logic [31:0] tgt);
    bit          g, rv, rdy, rd;
    logic [31:0] t;
    inflight_t   h;
    inflight_t   n;
    @(negedge clk_i);

    check_eq("valid", instr_valid_o, (mq.size() != 0));
    if (mq.size() != 0) begin
      check_eq("instr_pc", instr_pc_o, mq[0]);
      check_eq("instr",    instr_o,    mem_word(mq[0]));
      check_eq("pc_plus4", pc_plus4_o, mq[0] + 32'd4);
    end
    check_eq("req", imem_req_o, (stale == 0) && (mq.size() + inflight.size() < DEPTH));
    if (imem_req_o) check_eq("addr", imem_addr_o, mfetch);

    rd  = force_redir || ($urandom_range(99) < redir_pct);
    t   = force_redir ? tgt : $urandom;
    g   = ($urandom_range(99) < gnt_pct);
    rdy = ($urandom_range(99) < ready_pct);
    rv  = (inflight.size() != 0) && (inflight[0].due <= cyc);

    imem_gnt_i    = g;
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? mem_word(inflight[0].addr) : $urandom;
    instr_ready_i = rdy;
    redirect_i    = rd;
    redirect_pc_i = t;

    // Consumption: delivered addresses must be strictly sequential since the last redirect.
    if ((mq.size() != 0) && rdy && !rd) begin
      check_eq("seq_pc", instr_pc_o, exp_seq);
      delivered.push_back(instr_pc_o);
      delivered_p4.push_back(pc_plus4_o);
      exp_seq = exp_seq + 32'd4;
      n_consumed++;
      void'(mq.pop_front());
    end

    if (imem_req_o && g) begin
      n.addr = mfetch;
      n.due  = cyc + $urandom_range(lat_hi, lat_lo);
      inflight.push_back(n);
      mfetch = mfetch + 32'd4;
      n_grants++;
    end

    if (rv) begin
      h = inflight.pop_front();
      if (stale > 0) stale--;
      else if (!rd) mq.push_back(h.addr);
    end

    if (rd) begin
      mq.delete();
      delivered.delete();
      delivered_p4.delete();
      mfetch  = {t[31:2], 2'b00};
      exp_seq = mfetch;
      stale   = inflight.size();
    end
    cyc++;
  endtask

  task automatic set_knobs(input int g, input int r, input int rd, input int lo, input int hi);
    gnt_pct   = g;
    ready_pct = r;
    redir_pct = rd;
    lat_lo    = lo;
    lat_hi    = hi;
  endtask

  initial begin
    cyc = 0;
    n_consumed = 0;
    n_grants = 0;
    set_knobs(0, 0, 0, 1, 1);

    // Streaming: one instruction per cycle from the third cycle after reset.
    do_reset();
    set_knobs(100, 100, 0, 1, 1);
    n_consumed = 0;
    repeat (20) step(1'b0, 32'h0);
    check_eq("t1_throughput", n_consumed, 32'd18);
    check_eq("t1_first_pc",   get_del(0), 32'h0);

    // Decode stalled: exactly DEPTH grants, then drain in order.
    do_reset();
    set_knobs(100, 0, 0, 1, 1);
    n_grants = 0;
    repeat (10) step(1'b0, 32'h0);
    check_eq("t2_grants", n_grants, DEPTH);
    set_knobs(100, 100, 0, 1, 1);
    n_consumed = 0;
    repeat (8) step(1'b0, 32'h0);
    check_eq("t2_drain_first", get_del(0), 32'h0);
    check_eq("t2_drain_last",  get_del(3), 32'hC);

    // Redirect with two reads in flight: both dropped, restart at aligned target.
    do_reset();
    set_knobs(100, 100, 0, 5, 5);
    repeat (2) step(1'b0, 32'h0);
    set_knobs(0, 100, 0, 1, 1);
    step(1'b1, 32'h0000_0103);
    set_knobs(100, 100, 0, 1, 1);
    repeat (12) step(1'b0, 32'h0);
    check_eq("t3_first_pc", get_del(0), 32'h0000_0100);

    // Redirect coinciding with a grant and a response.
    do_reset();
    set_knobs(100, 100, 0, 1, 1);
    repeat (5) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_2000);
    repeat (10) step(1'b0, 32'h0);
    check_eq("t4_first_pc", get_del(0), 32'h0000_2000);

    // Address wrap at the top of memory.
    step(1'b1, 32'hFFFF_FFF8);
    repeat (10) step(1'b0, 32'h0);
    check_eq("t5_pc0", get_del(0), 32'hFFFF_FFF8);
    check_eq("t5_pc1", get_del(1), 32'hFFFF_FFFC);
    check_eq("t5_pc2", get_del(2), 32'h0000_0000);
    check_eq("t5_p4",  get_p4(2),  32'h0000_0004);

    // Random traffic with a reset pulse in the middle.
    do_reset();
    set_knobs(60, 60, 3, 1, 5);
    repeat (1500) step(1'b0, 32'h0);
    do_reset();
    repeat (1500) step(1'b0, 32'h0);
    set_knobs(100, 100, 0, 1, 5);
    n_consumed = 0;
    repeat (40) step(1'b0, 32'h0);
    check_eq("t6_progress", (n_consumed > 10), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
